// File: rtl/i2c_master_ctrl_if.sv
// Request/response bundle between host logic and the I2C master controller.
// The host side drives the request (master modport); the controller answers on the slave modport.
interface i2c_master_ctrl_if;
    logic       start_req;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rd_data;

    modport master (
        output start_req, rw, addr, wr_data,
        input  busy, done, ack_err, rd_data
    );

    modport slave (
        input  start_req, rw, addr, wr_data,
        output busy, done, ack_err, rd_data
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP; done 80*QTR cycles after accept.
// One request at a time: start_req is only sampled in IDLE, nothing is queued while busy.
module i2c_master_ctrl #(
    parameter int QTR = 25
) (
    input  logic            clk,
    input  logic            reset_in,
    i2c_master_ctrl_if.slave req,
    inout  wire             scl,
    inout  wire             sda
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, STOP
    } state_t;

    state_t      state;
    logic [15:0] qtr_cnt;
    logic [1:0]  phase;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_nxt;
    logic [7:0]  addr_byte;
    logic [7:0]  data_byte;
    logic [7:0]  rd_shift;
    logic        rw_q;
    logic        scl_lo;
    logic        sda_lo;
    logic        busy_q;
    logic        done_q;
    logic        ack_err_q;
    logic [7:0]  rd_data_q;
    logic        tick;

    assign tick    = (qtr_cnt == 16'(QTR - 1));
    assign bit_nxt = bit_cnt + 3'd1;

    // Open-drain: only ever pull low, a 1 is a released line.
    assign scl = scl_lo ? 1'b0 : 1'bz;
    assign sda = sda_lo ? 1'b0 : 1'bz;

    assign req.busy    = busy_q;
    assign req.done    = done_q;
    assign req.ack_err = ack_err_q;
    assign req.rd_data = rd_data_q;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state     <= IDLE;
            qtr_cnt   <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            addr_byte <= '0;
            data_byte <= '0;
            rd_shift  <= '0;
            rw_q      <= 1'b0;
            scl_lo    <= 1'b0;
            sda_lo    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (req.start_req) begin
                    state     <= START;
                    busy_q    <= 1'b1;
                    ack_err_q <= 1'b0;
                    rw_q      <= req.rw;
                    // Sent LSB first: seven address bits, then R/W as the last bit.
                    addr_byte <= {req.rw, req.addr};
                    data_byte <= req.wr_data;
                    qtr_cnt   <= '0;
                    phase     <= '0;
                    bit_cnt   <= '0;
                end
            end else if (!tick) begin
                qtr_cnt <= qtr_cnt + 16'd1;
            end else begin
                qtr_cnt <= '0;
                phase   <= phase + 2'd1;
                case (phase)
                    2'd1: begin
                        // Entering phase 2: SCL released and the bus is sampled.
                        scl_lo <= 1'b0;
                        case (state)
                            START:            sda_lo <= 1'b1;
                            ADDR_ACK, WR_ACK: if (sda) ack_err_q <= 1'b1;
                            READ:             rd_shift[bit_cnt] <= sda;
                            default:          ;
                        endcase
                    end
                    2'd2: begin
                        if (state == STOP) sda_lo <= 1'b0;
                    end
                    2'd3: begin
                        // End of bit-time: choose next state and drive its phase-0 levels.
                        scl_lo <= 1'b1;
                        case (state)
                            START: begin
                                state  <= ADDR;
                                sda_lo <= ~addr_byte[0];
                            end
                            ADDR: begin
                                bit_cnt <= bit_nxt;
                                if (bit_cnt == 3'd7) begin
                                    state  <= ADDR_ACK;
                                    sda_lo <= 1'b0;
                                end else begin
                                    sda_lo <= ~addr_byte[bit_nxt];
                                end
                            end
                            ADDR_ACK: begin
                                if (ack_err_q) begin
                                    state  <= STOP;
                                    sda_lo <= 1'b1;
                                end else if (rw_q) begin
                                    state  <= READ;
                                    sda_lo <= 1'b0;
                                end else begin
                                    state  <= WRITE;
                                    sda_lo <= ~data_byte[0];
                                end
                            end
                            WRITE: begin
                                bit_cnt <= bit_nxt;
                                if (bit_cnt == 3'd7) begin
                                    state  <= WR_ACK;
                                    sda_lo <= 1'b0;
                                end else begin
                                    sda_lo <= ~data_byte[bit_nxt];
                                end
                            end
                            READ: begin
                                bit_cnt <= bit_nxt;
                                if (bit_cnt == 3'd7) state <= RD_ACK;
                                sda_lo <= 1'b0;
                            end
                            WR_ACK, RD_ACK: begin
                                state  <= STOP;
                                sda_lo <= 1'b1;
                            end
                            STOP: begin
                                state  <= IDLE;
                                scl_lo <= 1'b0;
                                sda_lo <= 1'b0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                if (rw_q && !ack_err_q) rd_data_q <= rd_shift;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench: two controllers (QTR=25 and QTR=1) each talking to a behavioural slave on pulled-up lines.
module tb_i2c_master_ctrl;
    localparam int Q0 = 25;
    localparam int Q1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    wire scl0, sda0, scl1, sda1;
    pullup (scl0);
    pullup (sda0);
    pullup (scl1);
    pullup (sda1);

    i2c_master_ctrl_if rq0 ();
    i2c_master_ctrl_if rq1 ();

    i2c_master_ctrl #(.QTR(Q0)) dut (
        .clk(clk), .reset_in(rst), .req(rq0), .scl(scl0), .sda(sda0)
    );
    i2c_master_ctrl #(.QTR(Q1)) dut_q1 (
        .clk(clk), .reset_in(rst), .req(rq1), .scl(scl1), .sda(sda1)
    );

    logic [1:0] slv_lo;
    assign sda0 = slv_lo[0] ? 1'b0 : 1'bz;
    assign sda1 = slv_lo[1] ? 1'b0 : 1'bz;

    logic [1:0] scl_v, sda_v, prev_scl, prev_sda;
    assign scl_v = {scl1, scl0};
    assign sda_v = {sda1, sda0};

    wire [1:0] busy_v    = {rq1.busy, rq0.busy};
    wire [1:0] done_v    = {rq1.done, rq0.done};
    wire [1:0] ack_err_v = {rq1.ack_err, rq0.ack_err};

    logic [1:0]  ack_addr, ack_data;
    logic [7:0]  rd_byte [2];
    int          fall_n [2];
    int          rise_n [2];
    int          stop_n [2];
    logic [31:0] cap [2];

    // Slave decision for the bit that starts at SCL fall number f.
    function automatic logic slave_bit(input int g, input int f);
        logic [7:0] b;
        b = rd_byte[g];
        if (f == 8) return ack_addr[g];
        if (!ack_addr[g]) return 1'b0;
        if (cap[g][7] && f >= 9 && f <= 16) return !b[f-9];
        if (!cap[g][7] && f == 17) return ack_data[g];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                prev_scl[g] <= 1'b1;
                prev_sda[g] <= 1'b1;
                slv_lo[g]   <= 1'b0;
                fall_n[g]   <= 0;
                rise_n[g]   <= 0;
                stop_n[g]   <= 0;
                cap[g]      <= '0;
            end else begin
                prev_scl[g] <= scl_v[g];
                prev_sda[g] <= sda_v[g];
                if (prev_scl[g] && scl_v[g] && prev_sda[g] && !sda_v[g]) begin
                    fall_n[g] <= 0;
                    rise_n[g] <= 0;
                    slv_lo[g] <= 1'b0;
                end else if (prev_scl[g] && scl_v[g] && !prev_sda[g] && sda_v[g]) begin
                    stop_n[g] <= stop_n[g] + 1;
                end
                if (!prev_scl[g] && scl_v[g]) begin
                    if (rise_n[g] < 32) cap[g][rise_n[g]] <= sda_v[g];
                    rise_n[g] <= rise_n[g] + 1;
                end
                if (prev_scl[g] && !scl_v[g]) begin
                    fall_n[g] <= fall_n[g] + 1;
                    slv_lo[g] <= slave_bit(g, fall_n[g]);
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int g, input logic rw, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        if (g == 0) begin
            rq0.start_req = 1'b1; rq0.rw = rw; rq0.addr = a; rq0.wr_data = d;
        end else begin
            rq1.start_req = 1'b1; rq1.rw = rw; rq1.addr = a; rq1.wr_data = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req(input int g);
        if (g == 0) rq0.start_req = 1'b0;
        else        rq1.start_req = 1'b0;
    endtask

    task automatic wait_done(input int g, input int limit, output int lat);
        lat = 0;
        while (lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_v[g]) return;
        end
        lat = -1;
    endtask

    task automatic txn(input int g, input string tag, input logic rw, input logic [6:0] a,
                       input logic [7:0] d, input int exp_lat, input logic exp_err,
                       input logic [7:0] exp_rd, input int exp_rise);
        int lat;
        int s0;
        logic [7:0] rdv;
        s0 = stop_n[g];
        issue(g, rw, a, d);
        chk({tag, "_busy_on_accept"}, 32'(busy_v[g]), 32'd1);
        drop_req(g);
        wait_done(g, exp_lat + 200, lat);
        rdv = (g == 0) ? rq0.rd_data : rq1.rd_data;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_at_done"}, 32'(busy_v[g]), 32'd0);
        chk({tag, "_ack_err"}, 32'(ack_err_v[g]), 32'(exp_err));
        chk({tag, "_rd_data"}, 32'(rdv), 32'(exp_rd));
        chk({tag, "_scl_rises"}, rise_n[g], exp_rise);
        chk({tag, "_stop_seen"}, stop_n[g] - s0, 32'd1);
        chk({tag, "_addr_bits"}, 32'(cap[g][7:0]), 32'({rw, a}));
        if (exp_rise == 19) begin
            chk({tag, "_data_bits"}, 32'(cap[g][16:9]), rw ? 32'(rd_byte[g]) : 32'(d));
            if (rw) chk({tag, "_master_nack"}, 32'(cap[g][17]), 32'd1);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done_v[g]), 32'd0);
    endtask

    initial begin
        int lat;
        int dn;
        rst = 1'b1;
        rq0.start_req = 1'b0; rq0.rw = 1'b0; rq0.addr = '0; rq0.wr_data = '0;
        rq1.start_req = 1'b0; rq1.rw = 1'b0; rq1.addr = '0; rq1.wr_data = '0;
        ack_addr = 2'b11;
        ack_data = 2'b11;
        rd_byte[0] = 8'h00;
        rd_byte[1] = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        chk("rst_ack_err", 32'(ack_err_v), 32'd0);
        chk("rst_rd_data", 32'(rq0.rd_data), 32'h00);
        chk("rst_lines", {30'd0, scl0, sda0}, 32'h3);

        txn(0, "wr", 1'b0, 7'h2C, 8'hA5, 80*Q0, 1'b0, 8'h00, 19);

        rd_byte[0] = 8'h3C;
        txn(0, "rd", 1'b1, 7'h51, 8'h00, 80*Q0, 1'b0, 8'h3C, 19);

        ack_addr[0] = 1'b0;
        txn(0, "addr_nack", 1'b0, 7'h2C, 8'h11, 44*Q0, 1'b1, 8'h3C, 10);

        ack_addr[0] = 1'b1;
        ack_data[0] = 1'b0;
        txn(0, "data_nack", 1'b0, 7'h33, 8'hFF, 80*Q0, 1'b1, 8'h3C, 19);
        ack_data[0] = 1'b1;

        // start_req left high across the whole transaction
        issue(0, 1'b0, 7'h10, 8'h5A);
        chk("hold_busy", 32'(busy_v[0]), 32'd1);
        wait_done(0, 100*Q0, lat);
        chk("hold_first_latency", lat, 80*Q0);
        @(posedge clk);
        #1;
        chk("hold_reaccept_busy", 32'(busy_v[0]), 32'd1);
        chk("hold_reaccept_done_low", 32'(done_v[0]), 32'd0);
        drop_req(0);
        wait_done(0, 100*Q0, lat);
        chk("hold_second_latency", lat, 80*Q0);
        @(posedge clk);
        #1;
        chk("hold_idle_after", 32'(busy_v[0]), 32'd0);

        // reset in the middle of the write data byte (first data bit is a 0)
        issue(0, 1'b0, 7'h2C, 8'hA4);
        drop_req(0);
        repeat (40*Q0) @(posedge clk);
        #1;
        chk("pre_rst_scl_low", 32'(scl0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_lines", {30'd0, scl0, sda0}, 32'h3);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (100*Q0) begin
            @(posedge clk);
            #1;
            if (done_v[0]) dn++;
        end
        chk("midrst_no_done", dn, 32'd0);

        txn(1, "q1_wr", 1'b0, 7'h2C, 8'hA5, 80*Q1, 1'b0, 8'h00, 19);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
